// File: rtl/boot_mem_responder_pkg.sv
// Shared constants and helpers for the boot memory responder.
package boot_mem_responder_pkg;

  localparam int unsigned WORD_LEN = 32;

  // ADDI x0,x0,0 -- keeps the core's exit decode low while no RAM word is presented.
  localparam logic [WORD_LEN-1:0] NOP_INST = 32'h0000_0013;

  // Loader FSM state codes.
  localparam logic [0:0] LD_LOAD = 1'b0;
  localparam logic [0:0] LD_RUN  = 1'b1;

  // Source of a registered read output for the cycle after the read.
  typedef enum logic [1:0] {
    RSEL_NOP  = 2'd0,
    RSEL_ZERO = 2'd1,
    RSEL_RAM  = 2'd2
  } rd_sel_t;

  // Place a loader byte into its little-endian lane of the word being assembled.
  function automatic logic [WORD_LEN-1:0] merge_lane(
    input logic [WORD_LEN-1:0] acc,
    input logic [7:0]          b,
    input logic [1:0]          lane
  );
    return acc | (WORD_LEN'(b) << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/boot_mem_responder_mem_array.sv
// Word RAM: two synchronous read ports, one write port, read-first on collisions.
module mem_array
  import boot_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic [WORD_LEN-1:0] a_rdata,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic [WORD_LEN-1:0] b_rdata,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WORD_LEN-1:0] wdata
);

  logic [WORD_LEN-1:0] ram [DEPTH_WORDS];

  // Both reads sample the array before this edge's write lands, so a same-word read returns old data.
  always_ff @(posedge clk) begin
    a_rdata <= ram[a_addr];
    b_rdata <= ram[b_addr];
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/boot_mem_responder.sv
// Memory-side responder: boot loader fills RAM from a byte stream while holding
// the core in reset, then serves instruction fetches, loads and stores.
module boot_mem_responder
  import boot_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned BOOT_LOAD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  output logic [31:0] inst,
  input  logic [31:0] addr_d,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_rst_n,
  output logic        err_oob,
  output logic        err_misalign
);

  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS);
  localparam logic [0:0]  RESET_STATE = (BOOT_LOAD != 0) ? LD_LOAD : LD_RUN;

  logic [0:0]          state_q;
  logic [1:0]          byte_cnt_q;
  logic [ADDR_W:0]     wptr_q;
  logic [WORD_LEN-1:0] asm_q;
  logic                err_oob_q;
  logic                err_mis_q;
  rd_sel_t             isel_q;
  rd_sel_t             dsel_q;

  logic                in_run;
  logic                ld_accept;
  logic                ld_word_wr;
  logic                ld_ovf;
  logic [WORD_LEN-1:0] ld_word;
  logic                oob_i;
  logic                oob_d;
  logic                mis_d;
  logic [ADDR_W-1:0]   idx_i;
  logic [ADDR_W-1:0]   idx_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] ram_inst;
  logic [WORD_LEN-1:0] ram_data;

  // Byte-offset bits of the fetch address never select anything.
  logic unused_addr_i_lsb;
  assign unused_addr_i_lsb = ^addr_i[1:0];

  assign in_run     = (state_q == LD_RUN);
  assign ld_accept  = ld_valid && (state_q == LD_LOAD);
  assign ld_word    = merge_lane(asm_q, ld_byte, byte_cnt_q);
  assign ld_word_wr = ld_accept && ((byte_cnt_q == 2'd3) || ld_last);
  assign ld_ovf     = ld_word_wr && wptr_q[ADDR_W];

  assign oob_i = |addr_i[31:ADDR_W+2];
  assign oob_d = |addr_d[31:ADDR_W+2];
  assign mis_d = (addr_d[1:0] != 2'b00);
  assign idx_i = addr_i[ADDR_W+1:2];
  assign idx_d = addr_d[ADDR_W+1:2];

  assign ld_ready   = (state_q == LD_LOAD);
  assign core_rst_n = in_run;
  assign err_oob      = err_oob_q;
  assign err_misalign = err_mis_q;

  // Single write port shared by the loader (LOAD) and core stores (RUN).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (ld_word_wr && !ld_ovf) begin
      mem_we    = 1'b1;
      mem_waddr = wptr_q[ADDR_W-1:0];
      mem_wdata = ld_word;
    end else if (in_run && wen && !oob_d) begin
      mem_we    = 1'b1;
      mem_waddr = idx_d;
      mem_wdata = wdata;
    end
  end

  // Loader FSM, byte lane counter, word assembler and write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      byte_cnt_q <= '0;
      wptr_q     <= '0;
      asm_q      <= '0;
    end else if (ld_accept) begin
      if (ld_word_wr) begin
        asm_q      <= '0;
        byte_cnt_q <= '0;
        // Pointer parks at DEPTH_WORDS so every later word is seen as overflow.
        if (!wptr_q[ADDR_W]) begin
          wptr_q <= wptr_q + 1'b1;
        end
      end else begin
        asm_q      <= ld_word;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (ld_last) begin
        state_q <= LD_RUN;
      end
    end
  end

  // Sticky error flags and the output source selects for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_oob_q <= 1'b0;
      err_mis_q <= 1'b0;
      isel_q    <= RSEL_NOP;
      dsel_q    <= RSEL_ZERO;
    end else begin
      if (ld_ovf || (in_run && (oob_i || oob_d))) begin
        err_oob_q <= 1'b1;
      end
      if (in_run && wen && mis_d) begin
        err_mis_q <= 1'b1;
      end
      isel_q <= in_run ? (oob_i ? RSEL_ZERO : RSEL_RAM) : RSEL_NOP;
      dsel_q <= (in_run && !oob_d) ? RSEL_RAM : RSEL_ZERO;
    end
  end

  // The RAM read registers have no reset, so resettable selects decide what the outputs show.
  always_comb begin
    unique case (isel_q)
      RSEL_RAM:  inst = ram_inst;
      RSEL_ZERO: inst = '0;
      default:   inst = NOP_INST;
    endcase
    rdata = (dsel_q == RSEL_RAM) ? ram_data : '0;
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .a_addr  (idx_i),
    .a_rdata (ram_inst),
    .b_addr  (idx_d),
    .b_rdata (ram_data),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata)
  );

endmodule

// File: tb/tb_boot_mem_responder.sv
// Directed bench for boot_mem_responder: a full-size instance and a 4-word instance.
module tb_boot_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic        rst, wen, ld_valid, ld_last, ld_ready, core_rst_n, err_oob, err_misalign;
  logic [31:0] addr_i, inst, addr_d, wdata, rdata;
  logic [7:0]  ld_byte;

  // 4-word instance for overflow
  logic        s_rst, s_wen, s_ld_valid, s_ld_last, s_ld_ready, s_core_rst_n, s_err_oob, s_err_misalign;
  logic [31:0] s_addr_i, s_inst, s_addr_d, s_wdata, s_rdata;
  logic [7:0]  s_ld_byte;

  int n_chk = 0;
  int n_bad = 0;

  boot_mem_responder #(.DEPTH_WORDS(4096), .BOOT_LOAD(1)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .inst(inst), .addr_d(addr_d), .wen(wen),
    .wdata(wdata), .rdata(rdata), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .core_rst_n(core_rst_n), .err_oob(err_oob), .err_misalign(err_misalign)
  );

  boot_mem_responder #(.DEPTH_WORDS(4), .BOOT_LOAD(1)) dut_s (
    .clk(clk), .rst(s_rst), .addr_i(s_addr_i), .inst(s_inst), .addr_d(s_addr_d), .wen(s_wen),
    .wdata(s_wdata), .rdata(s_rdata), .ld_valid(s_ld_valid), .ld_byte(s_ld_byte), .ld_last(s_ld_last),
    .ld_ready(s_ld_ready), .core_rst_n(s_core_rst_n), .err_oob(s_err_oob), .err_misalign(s_err_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic s_load_byte(input logic [7:0] b, input logic last);
    s_ld_valid = 1'b1; s_ld_byte = b; s_ld_last = last;
    @(negedge clk);
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
  endtask

  task automatic read_i(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    @(negedge clk);
    chk(tag, inst, exp);
  endtask

  task automatic s_read_i(input string tag, input logic [31:0] a, input logic [31:0] exp);
    s_addr_i = a;
    @(negedge clk);
    chk(tag, s_inst, exp);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = '0;
    addr_i = '0; addr_d = '0; wdata = '0;
    s_rst = 1'b1; s_wen = 1'b0; s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_byte = '0;
    s_addr_i = '0; s_addr_d = '0; s_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;

    // Reset state
    chk("rst_inst",       inst, 32'h0000_0013);
    chk("rst_rdata",      rdata, 32'h0);
    chk("rst_err_oob",    32'(err_oob), 32'd0);
    chk("rst_err_mis",    32'(err_misalign), 32'd0);
    chk("rst_ld_ready",   32'(ld_ready), 32'd1);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);

    // Reset mid-load, then reload restarts at word 0
    load_byte(8'h55, 1'b0);
    load_byte(8'h66, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_ld_ready",   32'(ld_ready), 32'd1);
    chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("midrst_inst",       inst, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b0);
    load_byte(8'h44, 1'b1);
    read_i("reload_ram0", 32'h0, 32'h4433_2211);

    // Partial final word is zero-filled
    pulse_rst();
    load_byte(8'hAA, 1'b0);
    load_byte(8'hBB, 1'b0);
    load_byte(8'hCC, 1'b0);
    load_byte(8'hDD, 1'b0);
    load_byte(8'hEE, 1'b1);
    read_i("partial_ram0", 32'h0, 32'hDDCC_BBAA);
    read_i("partial_ram1", 32'h4, 32'h0000_00EE);

    // Two-word program image
    pulse_rst();
    load_byte(8'h13, 1'b0);
    load_byte(8'h00, 1'b0);
    load_byte(8'h00, 1'b0);
    load_byte(8'h00, 1'b0);
    load_byte(8'h93, 1'b0);
    load_byte(8'h00, 1'b0);
    chk("pre_last_ld_ready", 32'(ld_ready), 32'd1);
    load_byte(8'h50, 1'b0);
    load_byte(8'h00, 1'b1);
    chk("post_last_ld_ready",   32'(ld_ready), 32'd0);
    chk("post_last_core_rst_n", 32'(core_rst_n), 32'd1);
    read_i("img_ram0", 32'h0, 32'h0000_0013);
    read_i("img_ram1", 32'h4, 32'h0050_0093);

    // Store then read-during-write returns old data on both ports
    addr_i = 32'h100; addr_d = 32'h100; wen = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rdw_rdata_old", rdata, 32'h1234_5678);
    chk("rdw_inst_old",  inst, 32'h1234_5678);
    wen = 1'b0;
    @(negedge clk);
    chk("rdw_rdata_new", rdata, 32'hDEAD_BEEF);
    chk("rdw_inst_new",  inst, 32'hDEAD_BEEF);

    // Fetch in range, then one past the end
    addr_d = 32'h0;
    chk("pre_oob_err", 32'(err_oob), 32'd0);
    read_i("fetch_word1", 32'h4, 32'h0050_0093);
    read_i("fetch_oob", 32'h4000, 32'h0);
    chk("oob_err", 32'(err_oob), 32'd1);
    chk("oob_no_mis", 32'(err_misalign), 32'd0);

    // Misaligned store is forced word-aligned and flagged stickily
    addr_i = 32'h0; addr_d = 32'h102; wen = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    wen = 1'b0;
    chk("mis_flag", 32'(err_misalign), 32'd1);
    addr_d = 32'h100;
    @(negedge clk);
    chk("mis_aligned_data", rdata, 32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    chk("mis_sticky", 32'(err_misalign), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_clr_mis",   32'(err_misalign), 32'd0);
    chk("rst_clr_oob",   32'(err_oob), 32'd0);
    chk("rst_clr_inst",  inst, 32'h0000_0013);
    chk("rst_clr_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 4-word RAM loaded with 20 bytes: five words, the fifth overflows
    for (int i = 1; i <= 16; i++) begin
      s_load_byte(8'(i), 1'b0);
    end
    chk("ovf_not_yet", 32'(s_err_oob), 32'd0);
    for (int i = 17; i <= 20; i++) begin
      s_load_byte(8'(i), (i == 20));
    end
    chk("ovf_err",        32'(s_err_oob), 32'd1);
    chk("ovf_core_rst_n", 32'(s_core_rst_n), 32'd1);
    s_read_i("ovf_ram0", 32'h0, 32'h0403_0201);
    s_read_i("ovf_ram1", 32'h4, 32'h0807_0605);
    s_read_i("ovf_ram2", 32'h8, 32'h0C0B_0A09);
    s_read_i("ovf_ram3", 32'hC, 32'h100F_0E0D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
